// File: rtl/cpu_pipe_pkg.sv
// cpu_pipe_pkg: shared forward codes, latency constants and slot field widths for the in-order pipeline
package cpu_pipe_pkg;
    localparam int FWD_REGFILE = 0;
    localparam int FWD_MEM     = 2;
    localparam int FWD_WB      = 3;
    localparam int LAT_ALU     = 1;
    localparam int LAT_LOAD    = 2;
    localparam int LAT_W       = 2;
endpackage

// File: rtl/hazard_src_match.sv
// hazard_src_match: youngest in-flight writer search plus hazard and forward code for one ID source
// Ports: valid_i/use_i/src_i describe the source; slot_*_i are the tracked slots 1..N (1 = EX);
// hazard_o flags a result not yet available; fwd_o is the EX mux code (0 = register file).
module hazard_src_match
    import cpu_pipe_pkg::*;
#(
    parameter int ADDR_W   = 5,
    parameter int N        = 2,
    parameter int FWD_W    = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                       valid_i,
    input  logic                       use_i,
    input  logic [ADDR_W-1:0]          src_i,
    input  logic [N:1]                 slot_v_i,
    input  logic [N:1][ADDR_W-1:0]     slot_rd_i,
    input  logic [N:1][LAT_W-1:0]      slot_lat_i,
    output logic                       hazard_o,
    output logic [FWD_W-1:0]           fwd_o
);
    logic             hit, hit_ok;
    logic [FWD_W-1:0] k_hit;
    logic [LAT_W-1:0] lat_hit;

    // Scan oldest to youngest so the youngest match overwrites older ones.
    always_comb begin
        hit     = 1'b0;
        k_hit   = '0;
        lat_hit = '0;
        for (int k = N; k >= 1; k--) begin
            if (slot_v_i[k] && slot_rd_i[k] == src_i) begin
                hit     = 1'b1;
                k_hit   = FWD_W'(k);
                lat_hit = slot_lat_i[k];
            end
        end
    end

    assign hit_ok   = hit && valid_i && use_i && !(ZERO_REG != 0 && src_i == '0);
    assign hazard_o = hit_ok && k_hit < FWD_W'(lat_hit);
    // The producer moves one stage further by the time the consumer reaches EX.
    assign fwd_o    = hit_ok && !hazard_o ? k_hit + FWD_W'(1) : FWD_W'(FWD_REGFILE);
endmodule

// File: rtl/pipeline_hazard_scoreboard.sv
// pipeline_hazard_scoreboard: stall/bubble/forward controller tracking in-flight writers from EX to WB
// Ports: clk_i/rst_n_i clock and async active-low reset; issue_* describe the ID instruction;
// flush_i squashes ID; hold_i freezes everything; stall_o holds ID; fwd_a_o/fwd_b_o are the
// registered EX operand mux selects; stall_cnt_o saturates counting stall cycles.
module pipeline_hazard_scoreboard
    import cpu_pipe_pkg::*;
#(
    parameter int ADDR_W     = 5,
    parameter int PIPE_DEPTH = 3,
    parameter int MAX_LAT    = 2,
    parameter int FWD_W      = $clog2(PIPE_DEPTH + 1),
    parameter int ZERO_REG   = 1
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              issue_valid_i,
    input  logic [ADDR_W-1:0] issue_rs_i,
    input  logic [ADDR_W-1:0] issue_rt_i,
    input  logic              issue_use_rs_i,
    input  logic              issue_use_rt_i,
    input  logic [ADDR_W-1:0] issue_rd_i,
    input  logic              issue_regwrite_i,
    input  logic [1:0]        issue_lat_i,
    input  logic              flush_i,
    input  logic              hold_i,
    output logic              stall_o,
    output logic [FWD_W-1:0]  fwd_a_o,
    output logic [FWD_W-1:0]  fwd_b_o,
    output logic [31:0]       stall_cnt_o
);
    // The WB slot is never matched (write-through register file) and would only drop out,
    // so only slots 1..PIPE_DEPTH-1 are held.
    localparam int N = PIPE_DEPTH - 1;

    logic [N:1]             slot_v_q, slot_v_d;
    logic [N:1][ADDR_W-1:0] slot_rd_q, slot_rd_d;
    logic [N:1][LAT_W-1:0]  slot_lat_q, slot_lat_d;
    logic [FWD_W-1:0]       fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d, code_a, code_b;
    logic [31:0]            stall_cnt_q, stall_cnt_d;
    logic                   haz_a, haz_b, advance;

    hazard_src_match #(.ADDR_W(ADDR_W), .N(N), .FWD_W(FWD_W), .ZERO_REG(ZERO_REG)) u_src_a (
        .valid_i    (issue_valid_i),
        .use_i      (issue_use_rs_i),
        .src_i      (issue_rs_i),
        .slot_v_i   (slot_v_q),
        .slot_rd_i  (slot_rd_q),
        .slot_lat_i (slot_lat_q),
        .hazard_o   (haz_a),
        .fwd_o      (code_a)
    );

    hazard_src_match #(.ADDR_W(ADDR_W), .N(N), .FWD_W(FWD_W), .ZERO_REG(ZERO_REG)) u_src_b (
        .valid_i    (issue_valid_i),
        .use_i      (issue_use_rt_i),
        .src_i      (issue_rt_i),
        .slot_v_i   (slot_v_q),
        .slot_rd_i  (slot_rd_q),
        .slot_lat_i (slot_lat_q),
        .hazard_o   (haz_b),
        .fwd_o      (code_b)
    );

    // A flush already turns ID into a bubble, and a hold freezes ID anyway.
    assign stall_o = (haz_a | haz_b) & ~flush_i & ~hold_i;
    assign advance = issue_valid_i & ~flush_i & ~stall_o;

    always_comb begin
        slot_v_d   = slot_v_q;
        slot_rd_d  = slot_rd_q;
        slot_lat_d = slot_lat_q;
        if (!hold_i) begin
            for (int k = N; k >= 2; k--) begin
                slot_v_d[k]   = slot_v_q[k-1];
                slot_rd_d[k]  = slot_rd_q[k-1];
                slot_lat_d[k] = slot_lat_q[k-1];
            end
            slot_v_d[1]   = advance & issue_regwrite_i;
            slot_rd_d[1]  = advance ? issue_rd_i : '0;
            slot_lat_d[1] = advance ? issue_lat_i : '0;
        end
        fwd_a_d     = hold_i ? fwd_a_q : advance ? code_a : '0;
        fwd_b_d     = hold_i ? fwd_b_q : advance ? code_b : '0;
        stall_cnt_d = stall_o && stall_cnt_q != '1 ? stall_cnt_q + 32'd1 : stall_cnt_q;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            slot_v_q    <= '0;
            slot_rd_q   <= '0;
            slot_lat_q  <= '0;
            fwd_a_q     <= '0;
            fwd_b_q     <= '0;
            stall_cnt_q <= '0;
        end else begin
            slot_v_q    <= slot_v_d;
            slot_rd_q   <= slot_rd_d;
            slot_lat_q  <= slot_lat_d;
            fwd_a_q     <= fwd_a_d;
            fwd_b_q     <= fwd_b_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fwd_a_o     = fwd_a_q;
    assign fwd_b_o     = fwd_b_q;
    assign stall_cnt_o = stall_cnt_q;

    lat_legal: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        issue_valid_i && issue_regwrite_i |-> int'(issue_lat_i) >= LAT_ALU && int'(issue_lat_i) <= MAX_LAT);
endmodule

// File: tb/tb_pipeline_hazard_scoreboard.sv
// tb_pipeline_hazard_scoreboard: randomized and directed scoreboard bench for pipeline_hazard_scoreboard
module tb_pipeline_hazard_scoreboard;
    localparam int D = 3;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        issue_valid_i = 1'b0;
    logic [4:0]  issue_rs_i = '0;
    logic [4:0]  issue_rt_i = '0;
    logic        issue_use_rs_i = 1'b0;
    logic        issue_use_rt_i = 1'b0;
    logic [4:0]  issue_rd_i = '0;
    logic        issue_regwrite_i = 1'b0;
    logic [1:0]  issue_lat_i = 2'd1;
    logic        flush_i = 1'b0;
    logic        hold_i = 1'b0;
    logic        stall_o;
    logic [1:0]  fwd_a_o, fwd_b_o;
    logic [31:0] stall_cnt_o;

    pipeline_hazard_scoreboard dut (
        .clk_i            (clk_i),
        .rst_n_i          (rst_n_i),
        .issue_valid_i    (issue_valid_i),
        .issue_rs_i       (issue_rs_i),
        .issue_rt_i       (issue_rt_i),
        .issue_use_rs_i   (issue_use_rs_i),
        .issue_use_rt_i   (issue_use_rt_i),
        .issue_rd_i       (issue_rd_i),
        .issue_regwrite_i (issue_regwrite_i),
        .issue_lat_i      (issue_lat_i),
        .flush_i          (flush_i),
        .hold_i           (hold_i),
        .stall_o          (stall_o),
        .fwd_a_o          (fwd_a_o),
        .fwd_b_o          (fwd_b_o),
        .stall_cnt_o      (stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int         t;
        logic [4:0] rd;
        int         lat;
    } ins_t;

    typedef struct {
        logic        st;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [31:0] cnt;
    } exp_t;

    ins_t        writers[$];
    exp_t        exp_q[$];
    int          ptime = 0;
    logic [1:0]  m_fa = '0, m_fb = '0;
    logic [31:0] m_cnt = '0;
    int          n_vec = 0, n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a writer issued at pipeline time t is (ptime - t) stages past ID; its result
    // is usable once that age reaches its latency; WB-aged writers come from the register file.
    function automatic void lookup(input logic v, input logic u, input logic [4:0] s,
                                   output logic haz, output logic [1:0] code);
        haz  = 1'b0;
        code = 2'd0;
        if (!v || !u || s == 5'd0) return;
        for (int i = writers.size() - 1; i >= 0; i--) begin
            int age;
            age = ptime - writers[i].t;
            if (age >= 1 && age <= D - 1 && writers[i].rd == s) begin
                haz  = age < writers[i].lat;
                code = haz ? 2'd0 : 2'(age + 1);
                return;
            end
        end
    endfunction

    task automatic step(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic [4:0] rd,
                        input logic rw, input logic [1:0] lat, input logic fl, input logic hd);
        logic ha, hb, st, adv;
        logic [1:0] ca, cb;
        exp_t e;
        @(negedge clk_i);
        issue_valid_i    = v;
        issue_rs_i       = rs;
        issue_rt_i       = rt;
        issue_use_rs_i   = urs;
        issue_use_rt_i   = urt;
        issue_rd_i       = rd;
        issue_regwrite_i = rw;
        issue_lat_i      = lat;
        flush_i          = fl;
        hold_i           = hd;
        lookup(v, urs, rs, ha, ca);
        lookup(v, urt, rt, hb, cb);
        st = (ha || hb) && !fl && !hd;
        if (!hd) begin
            adv = v && !fl && !st;
            if (adv && rw) writers.push_back('{ptime, rd, int'(lat)});
            ptime++;
            while (writers.size() > 0 && ptime - writers[0].t > D) void'(writers.pop_front());
            m_fa = adv ? ca : 2'd0;
            m_fb = adv ? cb : 2'd0;
            if (st && m_cnt != 32'hFFFF_FFFF) m_cnt++;
        end
        e.st  = st;
        e.fa  = m_fa;
        e.fb  = m_fb;
        e.cnt = m_cnt;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'd1, 1'b0, 1'b0);
    endtask

    task automatic writer(input logic [4:0] rd, input logic [1:0] lat);
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, rd, 1'b1, lat, 1'b0, 1'b0);
    endtask

    task automatic after_edge(input string name, input logic [31:0] act_sel, input logic [31:0] exp);
        chk(name, act_sel, exp);
    endtask

    // Monitor: stall_o is checked once inputs settle, registered outputs after the edge.
    initial begin
        exp_t r;
        forever begin
            @(negedge clk_i);
            #2;
            if (exp_q.size() > 0) begin
                r = exp_q[0];
                chk("stall", 32'(stall_o), 32'(r.st));
                @(posedge clk_i);
                #1;
                chk("fwd_a", 32'(fwd_a_o), 32'(r.fa));
                chk("fwd_b", 32'(fwd_b_o), 32'(r.fb));
                chk("stall_cnt", stall_cnt_o, r.cnt);
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        int guard;
        #3;
        chk("rst_stall", 32'(stall_o), 32'd0);
        chk("rst_fwd_a", 32'(fwd_a_o), 32'd0);
        chk("rst_fwd_b", 32'(fwd_b_o), 32'd0);
        chk("rst_cnt", stall_cnt_o, 32'd0);
        @(negedge clk_i);
        rst_n_i = 1'b1;

        writer(5'd3, 2'd1);
        step(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 2'd1, 1'b0, 1'b0);
        #1 chk("alu_slot1_stall", 32'(stall_o), 32'd0);
        @(posedge clk_i); #2 chk("alu_slot1_fwd", 32'(fwd_a_o), 32'd2);

        writer(5'd3, 2'd1);
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'd1, 1'b0, 1'b0);
        step(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 2'd1, 1'b0, 1'b0);
        @(posedge clk_i); #2 chk("alu_slot2_fwd", 32'(fwd_a_o), 32'd3);

        writer(5'd4, 2'd2);
        step(1'b1, 5'd0, 5'd4, 1'b0, 1'b1, 5'd0, 1'b0, 2'd1, 1'b0, 1'b0);
        #1 chk("load_use_stall", 32'(stall_o), 32'd1);
        step(1'b1, 5'd0, 5'd4, 1'b0, 1'b1, 5'd0, 1'b0, 2'd1, 1'b0, 1'b0);
        #1 chk("load_use_release", 32'(stall_o), 32'd0);
        @(posedge clk_i); #2 chk("load_use_fwd_b", 32'(fwd_b_o), 32'd3);
        chk("load_use_cnt", stall_cnt_o, 32'd1);

        writer(5'd0, 2'd2);
        step(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 2'd1, 1'b0, 1'b0);
        #1 chk("r0_stall", 32'(stall_o), 32'd0);
        @(posedge clk_i); #2 chk("r0_fwd_a", 32'(fwd_a_o), 32'd0);

        writer(5'd5, 2'd1);
        writer(5'd5, 2'd1);
        step(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 2'd1, 1'b0, 1'b0);
        @(posedge clk_i); #2 chk("youngest_fwd_a", 32'(fwd_a_o), 32'd2);

        writer(5'd6, 2'd2);
        step(1'b1, 5'd6, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 2'd1, 1'b1, 1'b0);
        #1 chk("flush_stall", 32'(stall_o), 32'd0);
        @(posedge clk_i); #2 chk("flush_fwd_a", 32'(fwd_a_o), 32'd0);

        writer(5'd8, 2'd1);
        step(1'b1, 5'd8, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 2'd1, 1'b0, 1'b0);
        repeat (3) begin
            step(1'b1, 5'd8, 5'd8, 1'b1, 1'b1, 5'd0, 1'b0, 2'd1, 1'b0, 1'b1);
            @(posedge clk_i); #2 chk("hold_fwd_a", 32'(fwd_a_o), 32'd2);
        end
        step(1'b1, 5'd8, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 2'd1, 1'b0, 1'b0);
        @(posedge clk_i); #2 chk("post_hold_fwd_a", 32'(fwd_a_o), 32'd3);

        writer(5'd4, 2'd2);
        @(negedge clk_i);
        issue_valid_i  = 1'b1;
        issue_rt_i     = 5'd4;
        issue_use_rt_i = 1'b1;
        issue_use_rs_i = 1'b0;
        issue_regwrite_i = 1'b0;
        #1 chk("pre_reset_stall", 32'(stall_o), 32'd1);
        #2 rst_n_i = 1'b0;
        #1;
        chk("mid_reset_stall", 32'(stall_o), 32'd0);
        chk("mid_reset_fwd_a", 32'(fwd_a_o), 32'd0);
        chk("mid_reset_fwd_b", 32'(fwd_b_o), 32'd0);
        chk("mid_reset_cnt", stall_cnt_o, 32'd0);
        writers.delete();
        ptime = 0;
        m_fa  = '0;
        m_fb  = '0;
        m_cnt = '0;
        @(negedge clk_i);
        issue_valid_i = 1'b0;
        rst_n_i = 1'b1;

        repeat (1500) begin
            step($urandom_range(0, 99) < 85, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 $urandom_range(0, 99) < 80, $urandom_range(0, 99) < 80, 5'($urandom_range(0, 3)),
                 $urandom_range(0, 99) < 70, 2'($urandom_range(1, 2)),
                 $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 10);
        end
        idle();

        guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            @(negedge clk_i);
            guard++;
        end
        chk("drain", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
